i2c_slave_tx_burst: RTL and testbench

Parametrised I2C slave transmit path: returns one or more data words to the bus master during a read transaction, MSB first, with master-ACK/NACK handling and a small transmit FIFO so firmware can queue a burst ahead of time. It runs on the system clock, oversampling the bus lines. It sits behind the slave address decoder, which signals when a matched read has been acknowledged, and beside the slave receive path on the shared open-drain SDA pad.

---
 rtl/i2c_slave_tx_burst_pkg.sv | 20 ++
 rtl/i2c_slave_tx_burst_fifo.sv | 65 ++++++
 rtl/i2c_slave_tx_burst.sv | 164 ++++++++++++++++
 tb/tb_i2c_slave_tx_burst.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_tx_burst_pkg.sv
// i2c_pkg: shared definitions for the I2C slave transmit path.
//   tx_state_t     - transmit FSM states (IDLE, LOAD, SHIFT, MACK)
//   SDA_RELEASE    - SDA_oe value that lets the open-drain line float high
//   SDA_DRIVE_LOW  - SDA_oe value that pulls the line low
//   DEFAULT_WIDTH  - default bits per transferred word
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        MACK
    } tx_state_t;

    localparam logic SDA_RELEASE   = 1'b0;
    localparam logic SDA_DRIVE_LOW = 1'b1;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/i2c_slave_tx_burst_fifo.sv
// i2c_tx_fifo: synchronous WIDTH x DEPTH FIFO queuing words for the bus.
//   CLK, RST        - system clock, synchronous active-high reset
//   wr_en, wr_data  - push request and word
//   rd_en           - pop request (ignored while empty)
//   rd_data         - word at the head (valid while not empty)
//   full, empty     - occupancy flags derived from level
//   level           - occupancy, one bit wider than the pointers
module i2c_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = rd_en & ~empty;
    // A pop in the same cycle frees a slot, so a write to a full FIFO is kept.
    assign do_push = wr_en & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally at DEPTH.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/i2c_slave_tx_burst.sv
// i2c_slave_tx_burst: I2C slave read-data path. Shifts queued words onto
// SDA MSB first, samples the master ACK/NACK, and reloads from the FIFO
// while the master keeps acknowledging.
//   CLK, RST         - system clock (>= 8x SCL), synchronous active-high reset
//   SCL, SDA_in      - asynchronous bus lines, synchronised internally
//   SDA_oe           - 1 pulls SDA low, 0 releases it
//   wr_en, wr_data   - queue a word; full/level report occupancy
//   tx_start         - addressed read acknowledged, SCL low: begin sending
//   stop             - STOP / repeated START: abandon the transfer
//   busy             - FSM not idle
//   underrun         - pulse: a word was due with the FIFO empty (sends all ones)
//   nack_seen        - pulse: master NACKed, read finished
module i2c_slave_tx_burst
    import i2c_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     SCL,
    input  logic                     SDA_in,
    output logic                     SDA_oe,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     tx_start,
    input  logic                     stop,
    output logic                     busy,
    output logic                     underrun,
    output logic                     nack_seen
);

    localparam int BW = $clog2(WIDTH + 1);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_d;
    logic                   scl_rise;
    logic                   scl_fall;

    tx_state_t              state;
    logic [WIDTH-1:0]       shreg;
    logic [BW-1:0]          bit_cnt;
    logic                   ack_q;

    logic                   fifo_pop;
    logic                   fifo_empty;
    logic [WIDTH-1:0]       fifo_rd_data;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];
    assign busy  = (state != IDLE);

    // Synchronisers reset to 1 to match an idle bus; edge pulses are registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA_in};
            scl_d    <= scl_s;
            scl_rise <= scl_s & ~scl_d;
            scl_fall <= ~scl_s & scl_d;
        end
    end

    // stop outranks the LOAD pop so the FIFO is preserved on abort.
    assign fifo_pop = (state == LOAD) && !stop;

    i2c_tx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // SDA_oe is registered and always follows ~shreg[WIDTH-1] in SHIFT, so it
    // is computed from the value shreg takes on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            ack_q     <= 1'b0;
            SDA_oe    <= SDA_RELEASE;
            underrun  <= 1'b0;
            nack_seen <= 1'b0;
        end else begin
            underrun  <= 1'b0;
            nack_seen <= 1'b0;
            if (stop) begin
                state   <= IDLE;
                shreg   <= '0;
                bit_cnt <= '0;
                SDA_oe  <= SDA_RELEASE;
            end else begin
                case (state)
                    IDLE: begin
                        SDA_oe <= SDA_RELEASE;
                        if (tx_start) begin
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        bit_cnt <= BW'(WIDTH);
                        state   <= SHIFT;
                        if (fifo_empty) begin
                            shreg    <= '1;
                            SDA_oe   <= SDA_RELEASE;
                            underrun <= 1'b1;
                        end else begin
                            shreg  <= fifo_rd_data;
                            SDA_oe <= ~fifo_rd_data[WIDTH-1];
                        end
                    end
                    SHIFT: begin
                        if (scl_fall) begin
                            shreg   <= {shreg[WIDTH-2:0], 1'b0};
                            bit_cnt <= bit_cnt - BW'(1);
                            if (bit_cnt == BW'(1)) begin
                                state  <= MACK;
                                SDA_oe <= SDA_RELEASE;
                            end else begin
                                SDA_oe <= ~shreg[WIDTH-2];
                            end
                        end
                    end
                    MACK: begin
                        SDA_oe <= SDA_RELEASE;
                        if (scl_rise) begin
                            ack_q <= ~sda_s;
                        end else if (scl_fall) begin
                            if (ack_q) begin
                                state <= LOAD;
                            end else begin
                                nack_seen <= 1'b1;
                                state     <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_tx_burst.sv
// Bench for i2c_slave_tx_burst: a bus-master model clocks SCL and reads SDA,
// and a queue-based model of the FIFO predicts every returned word, underrun
// and NACK. A second instance with WIDTH=16 covers the wide word and
// reset-mid-word cases. Both share the open-drain SDA bus.
module tb_i2c_slave_tx_burst;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_b, scl, master_sda, stop;
    logic        wr_en_a, wr_en_b, tx_start_a, tx_start_b;
    logic [7:0]  wr_data_a;
    logic [15:0] wr_data_b;
    logic        oe_a, oe_b, full_a, full_b, busy_a, busy_b;
    logic        und_a, und_b, nack_a, nack_b;
    logic [2:0]  level_a, level_b;
    logic        sda_bus;

    // Wired-AND open-drain bus.
    assign sda_bus = master_sda & ~oe_a & ~oe_b;

    int checks = 0;
    int failures = 0;
    int und_cnt_a = 0, und_cnt_b = 0, nack_cnt_a = 0, nack_cnt_b = 0;
    int exp_und_a = 0, exp_nack_a = 0;
    logic [7:0] qa[$];

    i2c_slave_tx_burst #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) u_a (
        .CLK(clk), .RST(rst), .SCL(scl), .SDA_in(sda_bus), .SDA_oe(oe_a),
        .wr_en(wr_en_a), .wr_data(wr_data_a), .full(full_a), .level(level_a),
        .tx_start(tx_start_a), .stop(stop), .busy(busy_a),
        .underrun(und_a), .nack_seen(nack_a)
    );

    i2c_slave_tx_burst #(.WIDTH(16), .DEPTH(4), .SYNC_STAGES(2)) u_b (
        .CLK(clk), .RST(rst_b), .SCL(scl), .SDA_in(sda_bus), .SDA_oe(oe_b),
        .wr_en(wr_en_b), .wr_data(wr_data_b), .full(full_b), .level(level_b),
        .tx_start(tx_start_b), .stop(stop), .busy(busy_b),
        .underrun(und_b), .nack_seen(nack_b)
    );

    always @(negedge clk) begin
        if (und_a)  und_cnt_a++;
        if (und_b)  und_cnt_b++;
        if (nack_a) nack_cnt_a++;
        if (nack_b) nack_cnt_b++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] w);
        @(negedge clk); wr_en_a = 1'b1; wr_data_a = w;
        @(negedge clk); wr_en_a = 1'b0;
        if (qa.size() < 4) qa.push_back(w);
    endtask

    task automatic push_b(input logic [15:0] w);
        @(negedge clk); wr_en_b = 1'b1; wr_data_b = w;
        @(negedge clk); wr_en_b = 1'b0;
    endtask

    // SCL is left low after the address ACK, then the decoder pulses tx_start.
    task automatic start_tx(input int sel);
        scl = 1'b0;
        repeat (6) @(negedge clk);
        if (sel == 0) tx_start_a = 1'b1; else tx_start_b = 1'b1;
        @(negedge clk);
        tx_start_a = 1'b0; tx_start_b = 1'b0;
    endtask

    // Master clocks n data bits (16-CLK SCL period), sampling SDA mid-high.
    task automatic clock_bits(input int n, output logic [15:0] data);
        data = '0;
        for (int i = 0; i < n; i++) begin
            repeat (8) @(negedge clk); scl = 1'b1;
            repeat (4) @(negedge clk); data = {data[14:0], sda_bus};
            repeat (4) @(negedge clk); scl = 1'b0;
        end
    endtask

    task automatic ack_slot(input bit ack);
        repeat (4) @(negedge clk); master_sda = ~ack;
        repeat (4) @(negedge clk); scl = 1'b1;
        repeat (8) @(negedge clk); scl = 1'b0;
        repeat (2) @(negedge clk); master_sda = 1'b1;
    endtask

    task automatic word_a(input bit ack, input string tag);
        logic [7:0]  exp;
        logic [15:0] d;
        if (qa.size() > 0) exp = qa.pop_front();
        else begin exp = 8'hFF; exp_und_a++; end
        clock_bits(8, d);
        ack_slot(ack);
        if (!ack) exp_nack_a++;
        check(tag, {24'h0, d[7:0]}, {24'h0, exp});
    endtask

    task automatic summary_a(input string tag);
        repeat (8) @(negedge clk);
        check({tag, "_nack"},  nack_cnt_a, exp_nack_a);
        check({tag, "_und"},   und_cnt_a, exp_und_a);
        check({tag, "_busy"},  {31'h0, busy_a}, 0);
        check({tag, "_level"}, {29'h0, level_a}, qa.size());
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] w1;
        logic [7:0]  w, exp;
        int n, k;

        rst = 1'b1; rst_b = 1'b1; scl = 1'b1; master_sda = 1'b1; stop = 1'b0;
        wr_en_a = 1'b0; wr_en_b = 1'b0; wr_data_a = '0; wr_data_b = '0;
        tx_start_a = 1'b0; tx_start_b = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check("rst_oe",    {31'h0, oe_a}, 0);
        check("rst_busy",  {31'h0, busy_a}, 0);
        check("rst_level", {29'h0, level_a}, 0);
        check("rst_full",  {31'h0, full_a}, 0);
        check("rst_und",   {31'h0, und_a}, 0);
        check("rst_nack",  {31'h0, nack_a}, 0);
        check("rst_oe_b",  {31'h0, oe_b}, 0);

        // 0xA5 acknowledged, then a second word NACKed.
        push_a(8'hA5);
        push_a(8'($urandom));
        check("t1_level", {29'h0, level_a}, 2);
        start_tx(0);
        check("t1_busy", {31'h0, busy_a}, 1);
        word_a(1'b1, "t1_a5");
        word_a(1'b0, "t1_w1");
        summary_a("t1");

        // Three-word burst.
        push_a(8'h12); push_a(8'h34); push_a(8'h56);
        check("t2_level", {29'h0, level_a}, 3);
        start_tx(0);
        word_a(1'b1, "t2_12"); word_a(1'b1, "t2_34"); word_a(1'b0, "t2_56");
        summary_a("t2");

        // Empty FIFO: bus reads all ones, one underrun.
        start_tx(0);
        word_a(1'b0, "t3_ff");
        summary_a("t3");

        // stop mid-word: SDA released, remaining words kept.
        push_a(8'hF0); push_a(8'($urandom)); push_a(8'($urandom));
        start_tx(0);
        void'(qa.pop_front());
        clock_bits(4, d);
        check("t4_bits", {28'h0, d[3:0]}, 32'hF);
        repeat (6) @(negedge clk);
        check("t4_oe_pre", {31'h0, oe_a}, 1);
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        check("t4_oe",    {31'h0, oe_a}, 0);
        check("t4_busy",  {31'h0, busy_a}, 0);
        check("t4_level", {29'h0, level_a}, qa.size());
        start_tx(0);
        word_a(1'b1, "t4_d0"); word_a(1'b0, "t4_d1");
        summary_a("t4");

        // Overfill, then push concurrent with the LOAD pop while full.
        for (int i = 0; i < 5; i++) push_a(8'($urandom));
        check("t5_level", {29'h0, level_a}, 4);
        check("t5_full",  {31'h0, full_a}, 1);
        w = 8'($urandom);
        scl = 1'b0;
        repeat (6) @(negedge clk);
        tx_start_a = 1'b1;
        @(negedge clk);
        tx_start_a = 1'b0; wr_en_a = 1'b1; wr_data_a = w;
        exp = qa.pop_front();
        qa.push_back(w);
        @(negedge clk);
        wr_en_a = 1'b0;
        check("t5_level_pp", {29'h0, level_a}, 4);
        check("t5_full_pp",  {31'h0, full_a}, 1);
        clock_bits(8, d);
        ack_slot(1'b1);
        check("t5_w0", {24'h0, d[7:0]}, {24'h0, exp});
        word_a(1'b1, "t5_w1"); word_a(1'b1, "t5_w2");
        word_a(1'b1, "t5_w3"); word_a(1'b0, "t5_w4");
        summary_a("t5");

        // Random bursts, including underruns when reads outrun pushes.
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(0, 5);
            k = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) push_a(8'($urandom));
            check("rnd_level", {29'h0, level_a}, qa.size());
            start_tx(0);
            for (int j = 0; j < k; j++) word_a(j != k - 1, "rnd_word");
            summary_a("rnd");
        end

        // WIDTH=16: 0xBEEF then NACK.
        push_b(16'hBEEF);
        start_tx(1);
        clock_bits(16, d);
        ack_slot(1'b0);
        repeat (8) @(negedge clk);
        check("b_beef",  {16'h0, d}, 32'hBEEF);
        check("b_nack",  nack_cnt_b, 1);
        check("b_und",   und_cnt_b, 0);
        check("b_busy",  {31'h0, busy_b}, 0);
        check("b_level", {29'h0, level_b}, 0);

        // WIDTH=16: reset while driving a 0 bit.
        w1 = 16'($urandom) & 16'hFBFF;
        push_b(w1);
        push_b(16'($urandom));
        start_tx(1);
        clock_bits(5, d);
        check("b_bits", {27'h0, d[4:0]}, {27'h0, w1[15:11]});
        repeat (6) @(negedge clk);
        check("b_oe_pre",    {31'h0, oe_b}, 1);
        check("b_level_pre", {29'h0, level_b}, 1);
        @(negedge clk); rst_b = 1'b1;
        @(negedge clk); rst_b = 1'b0;
        check("b_rst_oe",    {31'h0, oe_b}, 0);
        check("b_rst_level", {29'h0, level_b}, 0);
        check("b_rst_busy",  {31'h0, busy_b}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
